// File: rtl/split_n_if.sv
// split_n_if: handshake bundle for the split_n N-way flit demultiplexer.
// Carries the data channel, the routing-token channel, the NOUT output
// channels and the drop counter. The slave modport is the split_n side.
//
// Handshake rule for every channel: an item moves on a rising clock edge
// where valid && ready are both high. The producer drives valid and data;
// the consumer drives ready.
interface split_n_if #(
  parameter int WIDTH = 11,
  parameter int NOUT  = 4,
  parameter int CW    = 2
);
  logic [WIDTH-1:0]      in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic [CW-1:0]         ctl_data;
  logic                  ctl_valid;
  logic                  ctl_ready;
  logic [NOUT*WIDTH-1:0] out_data;
  logic [NOUT-1:0]       out_valid;
  logic [NOUT-1:0]       out_ready;
  logic [7:0]            drop_cnt;

  modport master (
    output in_data, in_valid, ctl_data, ctl_valid, out_ready,
    input  in_ready, ctl_ready, out_data, out_valid, drop_cnt
  );

  modport slave (
    input  in_data, in_valid, ctl_data, ctl_valid, out_ready,
    output in_ready, ctl_ready, out_data, out_valid, drop_cnt
  );
endinterface

// File: rtl/split_n.sv
// split_n: clocked N-way split for the NoC router datapath.
// A flit is taken only together with a routing token (join); it is pushed
// into a 2-entry FIFO for the selected output. Selectors >= NOUT are
// consumed, discarded and counted in a saturating 8-bit counter.
// Optional feature macro: SPLIT_N_BCAST_EN adds a broadcast bit as the MSB
// of the token; a broadcast pushes the flit into every output FIFO at once.
module split_n #(
  parameter int WIDTH = 11,
  parameter int NOUT  = 4
) (
  input logic     clk,
  input logic     rst_n,
  split_n_if.slave bus
);
  localparam int SEL_W = $clog2(NOUT);
`ifdef SPLIT_N_BCAST_EN
  localparam int CW = SEL_W + 1;
`else
  localparam int CW = SEL_W;
`endif

  // Per-output FIFO: head_q is the entry presented on out_data, tail_q the
  // second slot. count_q is the registered occupancy 0..2.
  logic [NOUT-1:0][1:0]       count_q, count_d;
  logic [NOUT-1:0][WIDTH-1:0] head_q, head_d;
  logic [NOUT-1:0][WIDTH-1:0] tail_q, tail_d;
  logic [7:0]                 drop_q, drop_d;

  logic [SEL_W-1:0] sel;
  logic [NOUT-1:0]  hit;
  logic [NOUT-1:0]  full;
  logic [NOUT-1:0]  push;
  logic [NOUT-1:0]  pop;
  logic [NOUT-1:0]  valid;
  logic             sel_ok;
  logic             sel_full;
  logic             accept;
  logic             drop;
`ifdef SPLIT_N_BCAST_EN
  logic             bcast;
`endif

  // Join decision: accept flit and token together only when the target
  // FIFO(s) have room according to the registered counts.
  always_comb begin
    sel      = bus.ctl_data[SEL_W-1:0];
    hit      = '0;
    full     = '0;
    for (int i = 0; i < NOUT; i++) begin
      hit[i]  = (sel == SEL_W'(i));
      full[i] = (count_q[i] == 2'd2);
    end
    sel_ok   = |hit;
    sel_full = |(hit & full);
`ifdef SPLIT_N_BCAST_EN
    bcast  = bus.ctl_data[CW-1];
    accept = rst_n && bus.in_valid && bus.ctl_valid &&
             (bcast ? ~|full : !sel_full);
    push   = accept ? (bcast ? {NOUT{1'b1}} : hit) : '0;
    drop   = accept && !bcast && !sel_ok;
`else
    accept = rst_n && bus.in_valid && bus.ctl_valid && !sel_full;
    push   = accept ? hit : '0;
    drop   = accept && !sel_ok;
`endif
  end

  // FIFO next state: push writes the first free slot, pop shifts the tail
  // forward; push+pop with one entry replaces the head with the new flit.
  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    tail_d  = tail_q;
    for (int i = 0; i < NOUT; i++) begin
      valid[i] = (count_q[i] != 2'd0);
      pop[i]   = valid[i] && bus.out_ready[i];
      case ({push[i], pop[i]})
        2'b10: begin
          if (count_q[i] == 2'd0) head_d[i] = bus.in_data;
          else                    tail_d[i] = bus.in_data;
          count_d[i] = count_q[i] + 2'd1;
        end
        2'b01: begin
          head_d[i]  = tail_q[i];
          count_d[i] = count_q[i] - 2'd1;
        end
        2'b11: head_d[i] = bus.in_data;
        default: ;
      endcase
    end
    drop_d = (drop && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;
  end

  // State registers; reset discards all FIFO contents and the drop count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      drop_q  <= '0;
    end else begin
      count_q <= count_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      drop_q  <= drop_d;
    end
  end

  assign bus.in_ready  = accept;
  assign bus.ctl_ready = accept;
  assign bus.out_data  = head_q;
  assign bus.out_valid = valid;
  assign bus.drop_cnt  = drop_q;
endmodule

// File: tb/tb_split_n.sv
// tb_split_n: bench for split_n with two instances, NOUT=4 and NOUT=3,
// sharing the data/token inputs and having independent sinks.
module tb_split_n;
`ifdef SPLIT_N_BCAST_EN
  localparam int CW = 3;
`else
  localparam int CW = 2;
`endif

  logic        clk;
  logic        rst_n;
  logic        iv, cv;
  logic [2:0]  ctl;
  logic [10:0] data;
  logic [3:0]  ordy [2];

  logic        rdy  [2];
  logic        crdy [2];
  logic [3:0]  ov   [2];
  logic [43:0] od   [2];
  logic [7:0]  dc   [2];

  int total = 0;
  int bad   = 0;

  logic [10:0] mq [2][4][$];
  int          mdrop [2];

  split_n_if #(.WIDTH(11), .NOUT(4), .CW(CW)) if4 ();
  split_n_if #(.WIDTH(11), .NOUT(3), .CW(CW)) if3 ();

  split_n #(.WIDTH(11), .NOUT(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4.slave));
  split_n #(.WIDTH(11), .NOUT(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(if3.slave));

  assign if4.in_data   = data;
  assign if4.in_valid  = iv;
  assign if4.ctl_data  = ctl[CW-1:0];
  assign if4.ctl_valid = cv;
  assign if4.out_ready = ordy[0];
  assign if3.in_data   = data;
  assign if3.in_valid  = iv;
  assign if3.ctl_data  = ctl[CW-1:0];
  assign if3.ctl_valid = cv;
  assign if3.out_ready = ordy[1][2:0];

  assign rdy[0]  = if4.in_ready;
  assign rdy[1]  = if3.in_ready;
  assign crdy[0] = if4.ctl_ready;
  assign crdy[1] = if3.ctl_ready;
  assign ov[0]   = if4.out_valid;
  assign ov[1]   = {1'b0, if3.out_valid};
  assign od[0]   = if4.out_data;
  assign od[1]   = {11'd0, if3.out_data};
  assign dc[0]   = if4.drop_cnt;
  assign dc[1]   = if3.drop_cnt;

  // clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reset empties the reference model.
  always @(negedge rst_n) begin
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 4; i++) mq[k][i].delete();
      mdrop[k] = 0;
    end
  end

  // Scoreboard: compare outputs against the queue model every cycle, then
  // advance the model by what the coming rising edge must do.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      int          n;
      logic        bc;
      logic        ok;
      logic        any_full;
      int          s;
      n  = (k == 0) ? 4 : 3;
      s  = int'(ctl[1:0]);
      bc = 1'b0;
`ifdef SPLIT_N_BCAST_EN
      bc = ctl[2];
`endif
      any_full = 1'b0;
      for (int i = 0; i < n; i++) if (mq[k][i].size() >= 2) any_full = 1'b1;
      if (bc)          ok = !any_full;
      else if (s >= n) ok = 1'b1;
      else             ok = (mq[k][s].size() < 2);
      ok = ok && iv && cv && rst_n;
      chk($sformatf("in_ready[%0d]", k), rdy[k], ok);
      chk($sformatf("ctl_ready[%0d]", k), crdy[k], ok);
      for (int i = 0; i < n; i++) begin
        chk($sformatf("out_valid[%0d][%0d]", k, i), ov[k][i], mq[k][i].size() != 0);
        if (mq[k][i].size() != 0)
          chk($sformatf("out_data[%0d][%0d]", k, i), od[k][i*11 +: 11], mq[k][i][0]);
      end
      chk($sformatf("drop_cnt[%0d]", k), dc[k], mdrop[k]);
      if (rst_n) begin
        for (int i = 0; i < n; i++)
          if (mq[k][i].size() != 0 && ordy[k][i]) void'(mq[k][i].pop_front());
        if (ok) begin
          if (bc)          for (int i = 0; i < n; i++) mq[k][i].push_back(data);
          else if (s < n)  mq[k][s].push_back(data);
          else if (mdrop[k] < 255) mdrop[k]++;
        end
      end
    end
  end

  initial begin
    rst_n   = 1'b0;
    iv      = 1'b1;
    cv      = 1'b1;
    ctl     = 3'd0;
    data    = 11'h003;
    ordy[0] = 4'hF;
    ordy[1] = 4'hF;

    // reset values with offers pending
    step(3);
    @(negedge clk);
    chk("rst_in_ready", rdy[0], 1'b0);
    chk("rst_ctl_ready", crdy[1], 1'b0);
    chk("rst_out_valid", ov[0], 4'h0);
    chk("rst_out_data", od[0], 44'h0);
    chk("rst_drop", dc[1], 8'h0);
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("first_accept", rdy[0], 1'b1);
    step();
    iv = 1'b0;
    @(negedge clk);
    chk("first_latency_vld", ov[0], 4'b0001);
    chk("first_latency_dat", od[0][10:0], 11'h003);
    step(2);

    // drops on the 3-output instance
    iv = 1'b1; cv = 1'b1; ctl = 3'd3;
    for (int j = 0; j < 3; j++) begin
      data = 11'($urandom);
      @(negedge clk);
      chk("drop_ready", rdy[1], 1'b1);
      step();
    end
    iv = 1'b0;
    @(negedge clk);
    chk("drop_cnt3", dc[1], 8'd3);
    chk("drop_no_valid", ov[1], 4'h0);
    iv = 1'b1;
    step(300);
    iv = 1'b0;
    @(negedge clk);
    chk("drop_sat", dc[1], 8'd255);
    step(2);

    // unicast sweep at one flit per cycle
    iv = 1'b1; cv = 1'b1;
    for (int s = 0; s < 4; s++) begin
      ctl  = 3'(s);
      data = 11'(1 << s);
      @(negedge clk);
      chk("sweep_ready", rdy[0], 1'b1);
      if (s > 0) begin
        chk("sweep_vld", ov[0], 4'(1 << (s - 1)));
        chk("sweep_dat", od[0][(s-1)*11 +: 11], 11'(1 << (s - 1)));
      end
      step();
    end
    iv = 1'b0; cv = 1'b0;
    @(negedge clk);
    chk("sweep_vld3", ov[0], 4'b1000);
    chk("sweep_dat3", od[0][33 +: 11], 11'h008);
    step(2);

    // backpressure on output 2
    ordy[0][2] = 1'b0;
    iv = 1'b1; cv = 1'b1; ctl = 3'd2;
    data = 11'h7FF;
    @(negedge clk); chk("bp_acc1", rdy[0], 1'b1); step();
    data = 11'h123;
    @(negedge clk); chk("bp_acc2", rdy[0], 1'b1); step();
    data = 11'h456;
    @(negedge clk);
    chk("bp_stall", rdy[0], 1'b0);
    chk("bp_head", od[0][22 +: 11], 11'h7FF);
    step();
    ordy[0][2] = 1'b1;
    @(negedge clk); chk("bp_stall_pop", rdy[0], 1'b0); step();
    @(negedge clk);
    chk("bp_resume", rdy[0], 1'b1);
    chk("bp_head2", od[0][22 +: 11], 11'h123);
    step();
    iv = 1'b0; cv = 1'b0;
    @(negedge clk); chk("bp_head3", od[0][22 +: 11], 11'h456);
    step(3);

    // join: flit without token is never taken
    iv = 1'b1; cv = 1'b0; ctl = 3'd1; data = 11'h2AA;
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      chk("join_in_ready", rdy[0], 1'b0);
      chk("join_ctl_ready", crdy[0], 1'b0);
      chk("join_no_valid", ov[0], 4'h0);
      step();
    end
    cv = 1'b1;
    @(negedge clk); chk("join_go", rdy[0], 1'b1); step();
    iv = 1'b0; cv = 1'b0;
    @(negedge clk);
    chk("join_vld", ov[0], 4'b0010);
    chk("join_dat", od[0][11 +: 11], 11'h2AA);
    step(2);

    // mid-operation reset with FIFO[1] full
    ordy[0][1] = 1'b0;
    iv = 1'b1; cv = 1'b1; ctl = 3'd1;
    data = 11'h111; step();
    data = 11'h222; step();
    iv = 1'b0; cv = 1'b0;
    @(negedge clk); chk("mr_full", ov[0][1], 1'b1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("mr_valid", ov[0], 4'h0);
    chk("mr_data", od[0], 44'h0);
    chk("mr_drop", dc[1], 8'h0);
    chk("mr_ready", rdy[0], 1'b0);
    #1;
    rst_n = 1'b1;
    ordy[0] = 4'hF;
    step(4);
    @(negedge clk); chk("mr_no_emit", ov[0], 4'h0);
    step();

    // randomized traffic
    for (int j = 0; j < 2000; j++) begin
      iv      = ($urandom_range(0, 9) < 7);
      cv      = ($urandom_range(0, 9) < 7);
      ctl     = 3'($urandom_range(0, (1 << CW) - 1));
      data    = 11'($urandom);
      ordy[0] = 4'($urandom) | 4'($urandom);
      ordy[1] = 4'($urandom) | 4'($urandom);
      step();
    end
    iv = 1'b0; cv = 1'b0;
    ordy[0] = 4'hF; ordy[1] = 4'hF;
    step(3);

`ifdef SPLIT_N_BCAST_EN
    // broadcast
    iv = 1'b1; cv = 1'b1; ctl = 3'b100; data = 11'h055;
    @(negedge clk); chk("bc_ready", rdy[0], 1'b1); step();
    iv = 1'b0; cv = 1'b0;
    @(negedge clk);
    chk("bc_vld", ov[0], 4'hF);
    chk("bc_dat", od[0], {4{11'h055}});
    step();
    ordy[0][0] = 1'b0;
    iv = 1'b1; cv = 1'b1;
    data = 11'h0AA; step();
    data = 11'h0BB; step();
    data = 11'h0CC;
    @(negedge clk); chk("bc_stall", rdy[0], 1'b0); step();
    ordy[0][0] = 1'b1;
    @(negedge clk); chk("bc_stall_pop", rdy[0], 1'b0); step();
    @(negedge clk); chk("bc_resume", rdy[0], 1'b1); step();
    iv = 1'b0; cv = 1'b0;
    step(4);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/split_n.md
# split_n

Clocked, parametrised N-way split (demultiplexer) for the network-on-chip router datapath. A flit is taken from the data channel only together with a routing token from the control channel (CSP-style join). It is steered to one of NOUT output channels through a per-output 2-entry FIFO. Invalid selectors are consumed, dropped and counted. This block is the generalised successor of the fixed two-way 11-bit split.

## Interface
Parameters:
- WIDTH, 11, flit width in bits
- NOUT, 4, number of output channels (2..16)
- SEL_W, derived, $clog2(NOUT); not overridable

Ports:
- clk  in  1  clock; all state on rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- in_data  in  WIDTH  flit payload
- in_valid  in  1  flit offered
- in_ready  out  1  flit consumed this cycle
- ctl_data  in  CW  routing token; CW = SEL_W, or SEL_W+1 with SPLIT_N_BCAST_EN
- ctl_valid  in  1  token offered
- ctl_ready  out  1  token consumed this cycle
- out_data  out  NOUT*WIDTH  output i at bits [i*WIDTH +: WIDTH]
- out_valid  out  NOUT  output i holds a flit
- out_ready  in  NOUT  output i sink accepts
- drop_cnt  out  8  saturating count of dropped flits

## Operation
- Valid/ready handshake on every channel. A transfer occurs on a rising edge where valid && ready.
- Join rule: sel = ctl_data[SEL_W-1:0].
  - ok = in_valid && ctl_valid && (sel >= NOUT || count[sel] < 2).
  - in_ready = ctl_ready = ok. Flit and token are always consumed in the same cycle, never separately.
- Accept with sel < NOUT: flit is pushed into FIFO[sel].
- Accept with sel >= NOUT (possible only for non-power-of-2 NOUT): both items are consumed and the flit is discarded. drop_cnt increments and saturates at 255.
- Per-output FIFO: 2 entries with a registered count 0..2.
  - out_valid[i] = (count[i] != 0); out_data slice i = head entry.
  - Pop when out_valid[i] && out_ready[i].
- Order is preserved per output. There is no ordering relation across outputs.
- Fullness uses the registered count. On a full FIFO, a push in the same cycle as a pop is not allowed: ready stays low that cycle.
- Push and pop on a FIFO holding 1 entry in the same cycle: count stays 1, and the head becomes the new flit.
- Sustained 1 flit/cycle per output when the sink holds out_ready high.
- in_ready/ctl_ready may depend combinationally on ctl_data, in_valid and ctl_valid. No output depends combinationally on out_ready.

## Timing
- Reset (rst_n low, asynchronous): all counts 0, out_valid = 0, out_data = 0, drop_cnt = 0, in_ready = ctl_ready = 0. Contents are discarded, including during mid-operation reset.
- First accept is possible on the first rising edge after rst_n deasserts.
- Latency: accept at edge k, then out_valid[sel] is high after edge k (visible in cycle k+1).
- Backpressure: with out_ready[sel] = 0, two accepts fill FIFO[sel]. The join then stalls with in_ready = ctl_ready = 0 until the first edge after a pop.
- A stall on one output does not block tokens addressed to other outputs.

## Configuration
- SPLIT_N_BCAST_EN defined:
  - ctl_data is SEL_W+1 bits. MSB = 1 means broadcast.
  - A broadcast is accepted only when every FIFO has count < 2. The flit is then pushed into all NOUT FIFOs in one cycle.
  - A broadcast is never dropped, whatever the low bits.
- SPLIT_N_BCAST_EN undefined:
  - ctl_data is SEL_W bits. Unicast only.
  - No broadcast logic is present.

## Test plan
- Unicast sweep, NOUT=4, WIDTH=11, sinks always ready: send sel 0,1,2,3 with data 0x001,0x002,0x004,0x008 on consecutive cycles. Each out_valid[i] pulses one cycle later with the matching data, at 1 flit/cycle.
- Backpressure: out_ready[2] = 0; send sel=2 with data 0x7FF, 0x123, 0x456.
  - The first two are accepted. The third stalls with in_ready = 0.
  - Raise out_ready[2]. Outputs appear in order 0x7FF, 0x123, 0x456, and the third is accepted on the edge after the first pop.
- Join: hold in_valid = 1 with ctl_valid = 0 for 5 cycles. in_ready and ctl_ready stay 0 and no out_valid rises. Assert ctl_valid; the transfer completes in that cycle.
- Drop, NOUT=3: send sel=3 three times. in_ready = 1 each cycle, no out_valid, drop_cnt = 3. Send 300 drops; drop_cnt = 255.
- Reset: with FIFO[1] holding 2 flits, pulse rst_n low between edges. out_valid = 0 and drop_cnt = 0 immediately, with no flit emitted afterward.
- With SPLIT_N_BCAST_EN, NOUT=4: ctl = 3'b100 with data 0x055. All four out_valid rise after one edge with 0x055. With FIFO[0] full, the broadcast stalls until FIFO[0] pops.
